// File: rtl/syn_fifo_fwft_if.sv
// Bundles the FIFO's write, read, control and status signals into one port.
// master: the block that pushes/pops and watches the flags. slave: the FIFO itself.
// Signals: flush, err_clr, wr_en, data_in, rd_en -> FIFO; data_out, flags, level <- FIFO.
interface syn_fifo_fwft_if #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 3
);
  logic                  flush;
  logic                  err_clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, err_clr, wr_en, data_in, rd_en,
    input  data_out, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

  modport slave (
    input  flush, err_clr, wr_en, data_in, rd_en,
    output data_out, empty, full, almost_empty, almost_full, level, overflow, underflow
  );
endinterface

// File: rtl/syn_fifo_fwft.sv
// Single-clock register-array FIFO with registered-read or first-word-fall-through output.
// Latency: FWFT=0 data_out valid one cycle after the read edge; FWFT=1 head word visible the cycle after it is written.
// Backpressure: writes refused when full unless a read is accepted the same cycle; refused ops set sticky error flags.
// Ports: clk, rst_n (async, active-low), bus (slave modport: flush/err_clr/wr_en/data_in/rd_en in;
//        data_out, empty/full/almost_empty/almost_full, level, overflow/underflow out).
module syn_fifo_fwft #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  syn_fifo_fwft_if.slave       bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic empty_w;
  logic full_w;
  logic ra;
  logic wa;
  logic ovf_set;
  logic udf_set;

  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == LW'(DEPTH));

  // Flush takes priority over both requests, so neither side is accepted that cycle.
  // A read frees a slot in the same edge, so a full FIFO still takes a simultaneous write.
  assign ra = bus.rd_en && !empty_w && !bus.flush;
  assign wa = bus.wr_en && !bus.flush && (!full_w || ra);

  // Requests dropped by a flush are intentional and do not count as errors.
  assign ovf_set = bus.wr_en && !wa && !bus.flush;
  assign udf_set = bus.rd_en && empty_w && !bus.flush;

  // Storage is deliberately not reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wa) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
      end else begin
        // Power-of-two depth: pointer wrap is the natural modulo of the adder.
        if (wa) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (ra) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        case ({wa, ra})
          2'b10:   level_q <= level_q + LW'(1);
          2'b01:   level_q <= level_q - LW'(1);
          default: level_q <= level_q;
        endcase
      end
      // A new error in the clearing cycle must not be lost, so set beats clear.
      if (ovf_set)          overflow_q <= 1'b1;
      else if (bus.err_clr) overflow_q <= 1'b0;
      if (udf_set)          underflow_q <= 1'b1;
      else if (bus.err_clr) underflow_q <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is shown combinationally from the array; zero while empty.
      assign bus.data_out = empty_w ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else if (bus.flush) begin
          dout_q <= '0;
        end else if (ra) begin
          dout_q <= mem[rd_ptr];
        end
      end
      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_full  = (level_q >= LW'(AF_THRESH));
  assign bus.almost_empty = (level_q <= LW'(AE_THRESH));
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_syn_fifo_fwft.sv
// Bench for syn_fifo_fwft: u0 is the default registered-read FIFO (depth 8),
// u1 is a depth-4 first-word-fall-through FIFO. A queue per instance holds the
// words expected to come out; status flags are predicted from a bench-side level.
module tb_syn_fifo_fwft;

  logic clk;
  logic rst_n;

  syn_fifo_fwft_if #(.DATA_WIDTH(72), .ADDR_WIDTH(3)) b0 ();
  syn_fifo_fwft_if #(.DATA_WIDTH(72), .ADDR_WIDTH(2)) b1 ();

  syn_fifo_fwft #(.DATA_WIDTH(72), .ADDR_WIDTH(3), .FWFT(0)) u0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b0.slave)
  );

  syn_fifo_fwft #(.DATA_WIDTH(72), .ADDR_WIDTH(2), .FWFT(1)) u1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no_finish want finish");
    $fatal(1, "watchdog expired");
  end

  int total;
  int bad;

  logic [71:0] q0[$];
  logic [71:0] q1[$];
  int          lvl0, lvl1;
  logic [71:0] dout0;
  bit          ovf0, udf0, ovf1, udf1;

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic rst_models();
    q0.delete(); q1.delete();
    lvl0 = 0; lvl1 = 0; dout0 = '0;
    ovf0 = 0; udf0 = 0; ovf1 = 0; udf1 = 0;
  endtask

  // Depth 8, almost_full at >=7, almost_empty at <=1, registered read.
  task automatic st0(input string tag);
    check({tag, ".u0.level"}, 72'(b0.level),        72'(lvl0));
    check({tag, ".u0.empty"}, 72'(b0.empty),        72'(lvl0 == 0));
    check({tag, ".u0.full"},  72'(b0.full),         72'(lvl0 == 8));
    check({tag, ".u0.af"},    72'(b0.almost_full),  72'(lvl0 >= 7));
    check({tag, ".u0.ae"},    72'(b0.almost_empty), 72'(lvl0 <= 1));
    check({tag, ".u0.dout"},  b0.data_out,          dout0);
    check({tag, ".u0.ovf"},   72'(b0.overflow),     72'(ovf0));
    check({tag, ".u0.udf"},   72'(b0.underflow),    72'(udf0));
  endtask

  // Depth 4, almost_full at >=3, almost_empty at <=1, head word shown directly.
  task automatic st1(input string tag);
    logic [71:0] head;
    head = (q1.size() != 0) ? q1[0] : 72'h0;
    check({tag, ".u1.level"}, 72'(b1.level),        72'(lvl1));
    check({tag, ".u1.empty"}, 72'(b1.empty),        72'(lvl1 == 0));
    check({tag, ".u1.full"},  72'(b1.full),         72'(lvl1 == 4));
    check({tag, ".u1.af"},    72'(b1.almost_full),  72'(lvl1 >= 3));
    check({tag, ".u1.ae"},    72'(b1.almost_empty), 72'(lvl1 <= 1));
    check({tag, ".u1.dout"},  b1.data_out,          head);
    check({tag, ".u1.ovf"},   72'(b1.overflow),     72'(ovf1));
    check({tag, ".u1.udf"},   72'(b1.underflow),    72'(udf1));
  endtask

  task automatic op0(input bit w, input logic [71:0] d, input bit r,
                     input bit fl, input bit ec, input string tag);
    bit wa, ra;
    ra = r && !fl && (lvl0 != 0);
    wa = w && !fl && ((lvl0 != 8) || ra);
    b0.wr_en = w; b0.data_in = d; b0.rd_en = r; b0.flush = fl; b0.err_clr = ec;
    @(posedge clk); #1;
    b0.wr_en = 0; b0.rd_en = 0; b0.flush = 0; b0.err_clr = 0;
    if (!fl && w && !wa) ovf0 = 1; else if (ec) ovf0 = 0;
    if (!fl && r && lvl0 == 0) udf0 = 1; else if (ec) udf0 = 0;
    if (fl) begin
      q0.delete(); lvl0 = 0; dout0 = '0;
    end else begin
      if (wa) q0.push_back(d);
      if (ra) dout0 = q0.pop_front();
      lvl0 = lvl0 + int'(wa) - int'(ra);
    end
    st0(tag);
  endtask

  task automatic op1(input bit w, input logic [71:0] d, input bit r,
                     input bit fl, input bit ec, input string tag,
                     output bit wa_o, output bit ra_o);
    bit wa, ra;
    logic [71:0] popped;
    ra = r && !fl && (lvl1 != 0);
    wa = w && !fl && ((lvl1 != 4) || ra);
    b1.wr_en = w; b1.data_in = d; b1.rd_en = r; b1.flush = fl; b1.err_clr = ec;
    @(posedge clk); #1;
    b1.wr_en = 0; b1.rd_en = 0; b1.flush = 0; b1.err_clr = 0;
    if (!fl && w && !wa) ovf1 = 1; else if (ec) ovf1 = 0;
    if (!fl && r && lvl1 == 0) udf1 = 1; else if (ec) udf1 = 0;
    if (fl) begin
      q1.delete(); lvl1 = 0;
    end else begin
      if (wa) q1.push_back(d);
      if (ra) popped = q1.pop_front();
      lvl1 = lvl1 + int'(wa) - int'(ra);
    end
    wa_o = wa; ra_o = ra;
    st1(tag);
  endtask

  initial begin
    bit wa, ra, w, r;
    int nw, nr, cyc;
    total = 0; bad = 0;
    rst_n = 1'b0;
    b0.wr_en = 0; b0.rd_en = 0; b0.flush = 0; b0.err_clr = 0; b0.data_in = '0;
    b1.wr_en = 0; b1.rd_en = 0; b1.flush = 0; b1.err_clr = 0; b1.data_in = '0;
    rst_models();
    repeat (2) @(posedge clk);
    #1;
    st0("reset"); st1("reset");
    rst_n = 1'b1;

    // Fill to full, then drain in order.
    for (int i = 1; i <= 8; i++) op0(1, 72'(i), 0, 0, 0, $sformatf("fill%0d", i));
    for (int i = 1; i <= 8; i++) op0(0, 72'h0, 1, 0, 0, $sformatf("drain%0d", i));

    // Full with write+read, then write alone at full.
    for (int i = 1; i <= 8; i++) op0(1, 72'h10 + 72'(i), 0, 0, 0, $sformatf("refill%0d", i));
    op0(1, 72'h99, 1, 0, 0, "full_wr_rd");
    op0(1, 72'hDEAD, 0, 0, 0, "full_ovf");
    for (int i = 1; i <= 8; i++) op0(0, 72'h0, 1, 0, 0, $sformatf("redrain%0d", i));
    op0(0, 72'h0, 0, 0, 1, "ovf_clr");

    // Underflow, clear, and clear racing a new underflow.
    op0(0, 72'h0, 1, 0, 0, "udf");
    op0(0, 72'h0, 0, 0, 1, "udf_clr");
    op0(0, 72'h0, 1, 0, 1, "udf_clr_race");
    op0(0, 72'h0, 0, 0, 1, "udf_clr2");

    // FWFT: fall-through of a single word, then pop it.
    op1(1, 72'hAA, 0, 0, 0, "fwft_wr", wa, ra);
    op1(0, 72'h0, 1, 0, 0, "fwft_pop", wa, ra);

    // Concurrent random traffic on the depth-4 FIFO across several wraps.
    nw = 0; nr = 0; cyc = 0;
    while ((nw < 20 || nr < 20) && cyc < 400) begin
      w = (nw < 20) && ($urandom % 4 != 0);
      r = (nr < 20) && ($urandom % 4 != 0);
      op1(w, {8'hA5, 56'h0, 8'(nw)}, r, 0, 0, $sformatf("mix%0d", cyc), wa, ra);
      if (wa) nw++;
      if (ra) nr++;
      cyc++;
    end
    check("mix_done", 72'((nw == 20) && (nr == 20)), 72'(1));

    // Flush at level 5 with a concurrent write.
    for (int i = 1; i <= 5; i++) op0(1, 72'h30 + 72'(i), 0, 0, 0, $sformatf("pre_flush%0d", i));
    op0(1, 72'hEE, 0, 1, 0, "flush");

    // Asynchronous reset at level 5, observed before any clock edge.
    for (int i = 1; i <= 5; i++) op0(1, 72'h50 + 72'(i), 0, 0, 0, $sformatf("pre_rst%0d", i));
    rst_n = 1'b0;
    #2;
    rst_models();
    st0("arst"); st1("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op0(1, 72'h77, 0, 0, 0, "post_rst_wr");
    op0(0, 72'h0, 1, 0, 0, "post_rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syn_fifo_fwft.md
SYN_FIFO_FWFT -- requirements
Module: syn_fifo_fwft

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 72, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, pointer width; DEPTH = 2**ADDR_WIDTH entries, ADDR_WIDTH >= 1.
REQ-003 The block SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 The block SHALL have parameter AF_THRESH, default DEPTH-1, almost-full level, legal range 1..DEPTH.
REQ-005 The block SHALL have parameter AE_THRESH, default 1, almost-empty level, legal range 0..DEPTH-1.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous clear of FIFO contents.
REQ-009 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-010 The block SHALL have port data_in, input, DATA_WIDTH: write data.
REQ-011 The block SHALL have port rd_en, input, 1 bit: read request (pop in FWFT mode).
REQ-012 The block SHALL have port err_clr, input, 1 bit: synchronous clear of sticky error flags.
REQ-013 The block SHALL have port data_out, output, DATA_WIDTH: read data.
REQ-014 The block SHALL have ports empty, full, almost_empty, almost_full, output, 1 bit each: status flags.
REQ-015 The block SHALL have port level, output, ADDR_WIDTH+1: current occupancy, 0..DEPTH.
REQ-016 The block SHALL have ports overflow, underflow, output, 1 bit each: sticky error flags.

Function
REQ-017 Storage SHALL be an internal DEPTH x DATA_WIDTH register array; no external RAM; storage is not reset.
REQ-018 Write accepted (wa) SHALL equal wr_en && (!full || ra); read accepted (ra) SHALL equal rd_en && !empty.
REQ-019 On wa, the block SHALL store data_in at wr_ptr and increment wr_ptr modulo DEPTH; on ra, it SHALL increment rd_ptr modulo DEPTH.
REQ-020 level SHALL be registered: +1 on wa only, -1 on ra only, unchanged on both or neither; it never exceeds DEPTH or goes below 0.
REQ-021 empty = (level == 0); full = (level == DEPTH); almost_full = (level >= AF_THRESH); almost_empty = (level <= AE_THRESH); all derived from registered level.
REQ-022 FWFT=0: on ra, data_out SHALL load mem[rd_ptr] at the same edge (1-cycle read latency); otherwise data_out holds.
REQ-023 FWFT=1: data_out SHALL equal mem[rd_ptr] when !empty and 0 when empty; a word written into an empty FIFO appears the cycle after the write edge; rd_en pops the displayed word.
REQ-024 Simultaneous wr_en and rd_en when full SHALL perform both (level stays DEPTH); when empty, the write SHALL be accepted and the read rejected.
REQ-025 overflow SHALL set on wr_en && !wa; underflow SHALL set on rd_en && empty; both are sticky until err_clr; a set condition in the same cycle as err_clr wins.
REQ-026 flush SHALL, at the next edge, zero wr_ptr, rd_ptr and level, and zero data_out in FWFT=0 mode; wr_en/rd_en that cycle are ignored and raise no error flag.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL be seamless with no loss or duplication of data.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously set wr_ptr=0, rd_ptr=0, level=0, data_out=0, overflow=0, underflow=0, giving empty=1, full=0, almost_empty=1, almost_full=0.
REQ-029 Reset mid-operation SHALL discard all contents; the first read after release returns the first word written after release.

Verification
REQ-030 Defaults, FWFT=0: write 8 words 0x1..0x8, then read 8 -> full=1 after 8th write edge; data_out = 0x1..0x8 each 1 cycle after the read edge; empty=1 at end.
REQ-031 Full + wr_en + rd_en for one cycle -> level stays 8, word accepted; wr_en alone at full -> overflow=1, level 8, contents unchanged.
REQ-032 rd_en while empty -> underflow=1, data_out unchanged; assert err_clr -> underflow=0 next cycle; err_clr with a new underflow in the same cycle -> underflow stays 1.
REQ-033 FWFT=1: write 0xAA into empty FIFO -> data_out=0xAA, empty=0 next cycle with no rd_en; rd_en for one cycle -> empty=1, data_out=0.
REQ-034 Cycle 20 writes and 20 reads with concurrent traffic at ADDR_WIDTH=2 -> read data order equals write data order across wrap; almost_full at level >= AF_THRESH, almost_empty at level <= AE_THRESH.
REQ-035 Level 5 with flush plus wr_en -> level=0, empty=1, no overflow; rst_n pulse low with level 5 -> all outputs at reset values immediately, before the next clk edge.
